// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
//   Runs shift-add multiply (MULT/MULTU) and restoring divide (DIV/DIVU),
//   one iteration per clock, and arbitrates result writes against MTHI/MTLO.
//
// Ports
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        issue a mul/div (sampled only while idle)
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_val       multiplicand / dividend
//   rt_val       multiplier / divisor
//   mthi, mtlo   direct write of wdata to HI / LO (aborts an operation in flight)
//   wdata        data for mthi/mtlo
//   hi, lo       HI/LO registers
//   busy         operation in progress
//   done         one-cycle pulse when HI/LO first show a new result
//   div_by_zero  raised with done on divide by zero, cleared at next start
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  // Shared datapath: MUL keeps {partial product, multiplier}; DIV keeps
  // {remainder, dividend/quotient}. On divide by zero the low half holds raw rs.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_q, dz_d;

  logic                 rs_neg, rt_neg, rt_zero;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [WIDTH-1:0]     mul_add;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh, trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 mt_any;

  // Operand conditioning at issue.
  always_comb begin
    rs_neg  = op[0] & rs_val[WIDTH-1];
    rt_neg  = op[0] & rt_val[WIDTH-1];
    rs_mag  = rs_neg ? (~rs_val + 1'b1) : rs_val;
    rt_mag  = rt_neg ? (~rt_val + 1'b1) : rt_val;
    rt_zero = (rt_val == '0);
  end

  // Iteration datapath and final sign correction.
  always_comb begin
    mul_add  = acc_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, opnd_q};
    prod_fix = qneg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = qneg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    mt_any   = mthi | mtlo;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // start wins over a simultaneous mt write.
          opnd_d   = op[1] ? rt_mag : rs_mag;
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, (rt_zero ? rs_val : rs_mag)};
          end else begin
            acc_d = {{WIDTH{1'b0}}, rt_mag};
          end
          qneg_d   = rs_neg ^ rt_neg;
          rneg_d   = rs_neg;
          is_div_d = op[1];
          dz_d     = op[1] & rt_zero;
          dbz_d    = 1'b0;
          cnt_d    = '0;
          if (!op[1])       state_d = S_MUL;
          else if (rt_zero) state_d = S_FIX;
          else              state_d = S_DIV;
        end else if (mt_any) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      S_MUL, S_DIV: begin
        if (mt_any) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
          state_d = S_IDLE;
        end else begin
          if (state_q == S_MUL) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else if (!trial[WIDTH]) begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (mt_any) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end else begin
          if (dz_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          dbz_d  = dz_q;
          done_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the RISC core.
- Runs shift-add multiply and restoring divide for MULT/MULTU/DIV/DIVU and writes results into HI/LO.
- Arbitrates those result writes against direct MTHI/MTLO writes.
- Exports busy so the pipeline stalls MFHI/MFLO and further mul/div issue.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, core clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, issue a mul/div operation; sampled only when busy=0.
- op, input, 2, operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- rs_val, input, WIDTH, multiplicand or dividend.
- rt_val, input, WIDTH, multiplier or divisor.
- mthi, input, 1, write wdata to HI.
- mtlo, input, 1, write wdata to LO.
- wdata, input, WIDTH, data for mthi/mtlo.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse in the cycle HI/LO first show a new result.
- div_by_zero, output, 1, set together with done on divide by zero; cleared at the next start.

Behaviour:
- Reset (rst_n=0, asynchronous): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0. Reset mid-operation discards the operation; no done pulse follows.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 at edge E0:
  - Latch |rs_val| and |rt_val| for signed ops, raw values for unsigned ops.
  - Latch result signs: quotient/product sign = sign(rs)^sign(rt); remainder sign = sign(rs).
  - Clear div_by_zero and counter; go to MUL or DIV. busy=1 after E0.
- MUL: one shift-add step per edge on a 2*WIDTH accumulator. After WIDTH steps (edges E1..E_WIDTH) go to FIX.
- DIV: one restoring step per edge (shift remainder, trial subtract, set quotient bit). WIDTH steps, then FIX.
- Divide by zero (op[1]=1, rt_val=0 at E0): skip DIV and go to FIX. At E1: hi=rs_val, lo=all ones, div_by_zero=1, done=1.
- FIX, edge E_WIDTH+1:
  - Apply sign correction by two's-complement negate where the sign bit is set.
  - Product: hi=upper WIDTH bits, lo=lower WIDTH bits.
  - Divide: lo=quotient, hi=remainder.
  - done=1 for exactly one cycle, busy=0; return to IDLE.
- Latency: for a normal operation, hi/lo update, done=1 and busy=0 all appear after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32.
- Signed overflow, DIV of the most-negative value by -1 (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. No flag is raised.
- start while busy=1: ignored; the operation in flight is unaffected.
- mthi/mtlo while busy=0: the written register updates at the edge; the other register is unchanged.
- mthi/mtlo while busy=1: aborts the operation. The written register takes wdata, the other register keeps its pre-operation value. State=IDLE, busy=0 after that edge, no done pulse.
- start and mthi/mtlo in the same IDLE cycle: start wins and the mt write is dropped. The issue stage prevents this case; the controller behaviour is fixed anyway.
- mthi and mtlo together: both registers are written.
- hi/lo are never changed during iterations; they change only at FIX, on mt writes, or on reset.
- Counter wraps only through reload at start; it never free-runs in IDLE.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses 33 cycles after the start edge; busy high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5, rt=0 -> done after 1 cycle, hi=5, lo=0xFFFFFFFF, div_by_zero=1. The next start clears div_by_zero.
- Preload hi=0x11, lo=0x22; start MULTU 3*4; mtlo wdata=0xAB at iteration 10 -> lo=0xAB, hi=0x11, busy=0 next cycle, no done. A start issued while busy in a separate run is ignored.
- rst_n low at iteration 15 of a DIVU -> hi=lo=0 and busy=0 immediately (asynchronous). No done after release; a new MULTU 6*7 then gives lo=42.
